// File: rtl/maze_move_ctrl.sv
// Maze game sequencer: holds the player tile and level, validates each requested
// move against the level wall table and turns the tile into a block pixel position.
module maze_move_ctrl #(
    parameter int BLK_SIZE    = 10,
    parameter int MOVE_FRAMES = 8,
    parameter int LAST_LEVEL  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_restart,
    input  logic [9:0]  tile_w,
    input  logic [9:0]  tile_h,
    input  logic [4:0]  num_rows,
    input  logic [4:0]  num_cols,
    output logic [4:0]  qry_row,
    output logic [4:0]  qry_col,
    input  logic [3:0]  qry_walls,
    output logic [1:0]  level_select,
    output logic [10:0] blkpos_x,
    output logic [10:0] blkpos_y,
    output logic        game_done,
    output logic        move_busy
);

    typedef enum logic [2:0] {S_IDLE, S_QUERY, S_CHECK, S_UPDATE, S_GOAL, S_WIN} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam int               CNT_W      = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MOVE_FRAMES - 1);
    localparam logic [1:0]       LAST_LVL   = 2'(LAST_LEVEL);
    localparam logic [9:0]       BLK        = 10'(BLK_SIZE);

    state_t           state;
    dir_t             dir;
    dir_t             req_dir;
    logic [4:0]       row, col;
    logic [3:0]       walls;
    logic [CNT_W-1:0] rpt_cnt;
    logic             any_dir;
    logic             blocked;
    logic             at_goal;
    logic [9:0]       x_off, y_off;
    logic [10:0]      x_next, y_next;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        any_dir = btn_up | btn_down | btn_left | btn_right;
        req_dir = DIR_RIGHT;
        if (btn_up)        req_dir = DIR_UP;
        else if (btn_down) req_dir = DIR_DOWN;
        else if (btn_left) req_dir = DIR_LEFT;

        blocked = 1'b0;
        case (dir)
            DIR_UP:    blocked = walls[3] || (row == 5'd0);
            DIR_DOWN:  blocked = walls[2] || (row == num_rows - 5'd1);
            DIR_LEFT:  blocked = walls[1] || (col == 5'd0);
            DIR_RIGHT: blocked = walls[0] || (col == num_cols - 5'd1);
            default:   blocked = 1'b1;
        endcase

        at_goal = (row == num_rows - 5'd1) && (col == num_cols - 5'd1);

        // Arithmetic is done modulo 2^11, which equals truncating the full result.
        x_off  = (tile_w >= BLK) ? ((tile_w - BLK) >> 1) : 10'd0;
        y_off  = (tile_h >= BLK) ? ((tile_h - BLK) >> 1) : 10'd0;
        x_next = 11'(col) * 11'(tile_w) + 11'(x_off);
        y_next = 11'(row) * 11'(tile_h) + 11'(y_off);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            dir          <= DIR_UP;
            row          <= '0;
            col          <= '0;
            walls        <= '0;
            level_select <= '0;
            qry_row      <= '0;
            qry_col      <= '0;
            game_done    <= 1'b0;
            move_busy    <= 1'b0;
            rpt_cnt      <= '0;
        end else begin
            if (!any_dir) rpt_cnt <= '0;

            case (state)
                S_IDLE: begin
                    if (btn_restart) begin
                        level_select <= '0;
                        row          <= '0;
                        col          <= '0;
                        rpt_cnt      <= '0;
                    end else if (frame_tick && any_dir) begin
                        if (rpt_cnt == '0) begin
                            rpt_cnt   <= CNT_RELOAD;
                            dir       <= req_dir;
                            qry_row   <= row;
                            qry_col   <= col;
                            move_busy <= 1'b1;
                            state     <= S_QUERY;
                        end else begin
                            rpt_cnt <= rpt_cnt - CNT_W'(1);
                        end
                    end
                end
                S_QUERY: begin
                    walls <= qry_walls;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (blocked) begin
                        move_busy <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    case (dir)
                        DIR_UP:    row <= row - 5'd1;
                        DIR_DOWN:  row <= row + 5'd1;
                        DIR_LEFT:  col <= col - 5'd1;
                        default:   col <= col + 5'd1;
                    endcase
                    state <= S_GOAL;
                end
                S_GOAL: begin
                    move_busy <= 1'b0;
                    state     <= S_IDLE;
                    if (at_goal) begin
                        if (level_select < LAST_LVL) begin
                            level_select <= level_select + 2'd1;
                            row          <= '0;
                            col          <= '0;
                        end else begin
                            game_done <= 1'b1;
                            state     <= S_WIN;
                        end
                    end
                end
                S_WIN: begin
                    if (btn_restart) begin
                        level_select <= '0;
                        row          <= '0;
                        col          <= '0;
                        rpt_cnt      <= '0;
                        game_done    <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    move_busy <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blkpos_x <= '0;
            blkpos_y <= '0;
        end else begin
            blkpos_x <= x_next;
            blkpos_y <= y_next;
        end
    end

endmodule
